// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: default widths, opcodes and the controller's
// 12-bit control word layout.
package sap1_pkg;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_DATA_W = 8;

    localparam logic [3:0] LDA = 4'h0;
    localparam logic [3:0] ADD = 4'h1;
    localparam logic [3:0] SUB = 4'h2;
    localparam logic [3:0] OUT = 4'hE;
    localparam logic [3:0] HLT = 4'hF;

    // Field order matches the controller's output order, MSB first.
    typedef struct packed {
        logic Cp;
        logic Ep;
        logic Lm_barra;
        logic CE_barra;
        logic Li_barra;
        logic Ei_barra;
        logic La_barra;
        logic Ea;
        logic Su;
        logic Eu;
        logic Lb_barra;
        logic Lo_barra;
    } ctrl_word_t;

    function automatic logic [2:0] bus_driver_count(input ctrl_word_t c);
        return 3'(c.Ep) + 3'(!c.CE_barra) + 3'(!c.Ei_barra) + 3'(c.Ea) + 3'(c.Eu);
    endfunction

endpackage

// File: rtl/sap1_ram16x8.sv
// Program RAM: asynchronous read, synchronous write, contents survive reset.
module sap1_ram16x8 #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, RAM, IR, A, B, ALU and output register around a
// single priority-muxed 8-bit bus, with a sticky multi-driver flag.
module sap1_datapath
    import sap1_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                     clock,
    input  logic                     clr,
    input  logic                     Cp,
    input  logic                     Ep,
    input  logic                     Lm_barra,
    input  logic                     CE_barra,
    input  logic                     Li_barra,
    input  logic                     Ei_barra,
    input  logic                     La_barra,
    input  logic                     Ea,
    input  logic                     Su,
    input  logic                     Eu,
    input  logic                     Lb_barra,
    input  logic                     Lo_barra,
    input  logic                     prog_en,
    input  logic [ADDR_W-1:0]        prog_addr,
    input  logic [DATA_W-1:0]        prog_data,
    output logic [DATA_W-ADDR_W-1:0] ri,
    output logic [DATA_W-1:0]        W,
    output logic                     bus_conflict
);

    ctrl_word_t        ctrl;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] mar;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] bus;

    assign ctrl = {Cp, Ep, Lm_barra, CE_barra, Li_barra, Ei_barra,
                   La_barra, Ea, Su, Eu, Lb_barra, Lo_barra};

    sap1_ram16x8 #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_ram (
        .clock(clock),
        .we   (prog_en),
        .waddr(prog_addr),
        .wdata(prog_data),
        .raddr(mar),
        .rdata(ram_q)
    );

    // Modulo-2^DATA_W arithmetic; no carry or flags leave the datapath.
    assign alu = ctrl.Su ? (a - b) : (a + b);

    always_comb begin
        bus = '0;
        if (ctrl.Ep) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, pc};
        end else if (!ctrl.CE_barra) begin
            bus = ram_q;
        end else if (!ctrl.Ei_barra) begin
            bus = {{(DATA_W-ADDR_W){1'b0}}, ir[ADDR_W-1:0]};
        end else if (ctrl.Ea) begin
            bus = a;
        end else if (ctrl.Eu) begin
            bus = alu;
        end
    end

    // Every load samples the pre-edge bus, so drive-and-load holds the value.
    always_ff @(posedge clock or negedge clr) begin
        if (!clr) begin
            pc           <= '0;
            mar          <= '0;
            ir           <= '0;
            a            <= '0;
            b            <= '0;
            W            <= '0;
            bus_conflict <= 1'b0;
        end else begin
            if (ctrl.Cp)        pc  <= pc + ADDR_W'(1);
            if (!ctrl.Lm_barra) mar <= bus[ADDR_W-1:0];
            if (!ctrl.Li_barra) ir  <= bus;
            if (!ctrl.La_barra) a   <= bus;
            if (!ctrl.Lb_barra) b   <= bus;
            if (!ctrl.Lo_barra) W   <= bus;
            if (bus_driver_count(ctrl) > 3'd1) begin
                bus_conflict <= 1'b1;
            end
        end
    end

    assign ri = ir[DATA_W-1:ADDR_W];

endmodule

// File: tb/tb_sap1_datapath.sv
// Self-checking bench for sap1_datapath; internal registers are observed by
// routing them onto the bus and into W.
module tb_sap1_datapath;
    import sap1_pkg::*;

    logic       clock = 1'b0;
    logic       clr;
    ctrl_word_t cw;
    logic       prog_en;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] ri;
    logic [7:0] W;
    logic       bus_conflict;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       su;
        logic [7:0] exp;
    } alu_vec_t;

    alu_vec_t vecs[10];

    always #5 clock = ~clock;

    sap1_datapath dut (
        .clock       (clock),
        .clr         (clr),
        .Cp          (cw.Cp),
        .Ep          (cw.Ep),
        .Lm_barra    (cw.Lm_barra),
        .CE_barra    (cw.CE_barra),
        .Li_barra    (cw.Li_barra),
        .Ei_barra    (cw.Ei_barra),
        .La_barra    (cw.La_barra),
        .Ea          (cw.Ea),
        .Su          (cw.Su),
        .Eu          (cw.Eu),
        .Lb_barra    (cw.Lb_barra),
        .Lo_barra    (cw.Lo_barra),
        .prog_en     (prog_en),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .ri          (ri),
        .W           (W),
        .bus_conflict(bus_conflict)
    );

    function automatic ctrl_word_t idle();
        ctrl_word_t c;
        c = '0;
        c.Lm_barra = 1'b1;
        c.CE_barra = 1'b1;
        c.Li_barra = 1'b1;
        c.Ei_barra = 1'b1;
        c.La_barra = 1'b1;
        c.Lb_barra = 1'b1;
        c.Lo_barra = 1'b1;
        return c;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // One clock: drive controls, let the edge happen, settle 1 time unit.
    task automatic cyc(input ctrl_word_t c);
        cw = c;
        @(posedge clock);
        #1;
        cw = idle();
        prog_en = 1'b0;
    endtask

    task automatic prog(input logic [3:0] addr, input logic [7:0] data);
        prog_en   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        cyc(idle());
    endtask

    // Scoreboard: expected W queued as the source is driven, popped after the edge.
    task automatic show(input string name, input ctrl_word_t c, input logic [7:0] exp);
        c.Lo_barra = 1'b0;
        exp_q.push_back(exp);
        cyc(c);
        check(name, W, exp_q.pop_front());
    endtask

    task automatic pulse_clr();
        #2;
        clr = 1'b0;
        #1;
    endtask

    task automatic release_clr();
        @(negedge clock);
        clr = 1'b1;
    endtask

    // Uses RAM[0] as a staging cell; MAR is expected to be 0.
    task automatic load_a(input logic [7:0] v);
        ctrl_word_t c;
        prog(4'h0, v);
        c = idle(); c.CE_barra = 1'b0; c.La_barra = 1'b0;
        cyc(c);
    endtask

    task automatic load_b(input logic [7:0] v);
        ctrl_word_t c;
        prog(4'h0, v);
        c = idle(); c.CE_barra = 1'b0; c.Lb_barra = 1'b0;
        cyc(c);
    endtask

    initial begin
        ctrl_word_t c;
        cw = idle();
        prog_en = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        clr = 1'b0;

        // Programming with clr low, then a hand-run LDA 9 instruction.
        prog(4'h0, 8'h09);
        prog(4'h9, 8'h1C);
        check("reset_w", W, 8'h00);
        check("reset_ri", {4'h0, ri}, 8'h00);
        check("reset_conflict", {7'h0, bus_conflict}, 8'h00);
        release_clr();

        c = idle(); c.Ep = 1'b1; c.Lm_barra = 1'b0; cyc(c);
        c = idle(); c.Cp = 1'b1; cyc(c);
        c = idle(); c.CE_barra = 1'b0; c.Li_barra = 1'b0; cyc(c);
        check("fetch_ri", {4'h0, ri}, {4'h0, LDA});
        c = idle(); c.Ei_barra = 1'b0; c.Lm_barra = 1'b0; cyc(c);
        c = idle(); c.CE_barra = 1'b0; c.La_barra = 1'b0; cyc(c);
        c = idle(); c.Ea = 1'b1; show("lda_a", c, 8'h1C);
        c = idle(); c.Ep = 1'b1; show("lda_pc", c, 8'h01);
        c = idle(); c.CE_barra = 1'b0; c.Lb_barra = 1'b0; cyc(c);

        // Asynchronous reset mid-cycle with everything nonzero.
        pulse_clr();
        check("async_w", W, 8'h00);
        check("async_ri", {4'h0, ri}, 8'h00);
        release_clr();
        c = idle(); c.Ea = 1'b1; show("rst_a", c, 8'h00);
        c = idle(); c.Eu = 1'b1; show("rst_b", c, 8'h00);
        c = idle(); c.Ep = 1'b1; show("rst_pc", c, 8'h00);
        c = idle(); c.Ei_barra = 1'b0; show("rst_ir", c, 8'h00);
        c = idle(); c.CE_barra = 1'b0; show("rst_mar_ram", c, 8'h09);

        // ALU table; each entry loads A and B, runs Eu into A, then outputs A.
        vecs[0] = '{8'hF0, 8'h20, 1'b0, 8'h10};
        vecs[1] = '{8'h05, 8'h07, 1'b1, 8'hFE};
        vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00};
        vecs[4] = '{8'h00, 8'h01, 1'b1, 8'hFF};
        vecs[5] = '{8'h80, 8'h80, 1'b1, 8'h00};
        vecs[6] = '{8'h7F, 8'h7F, 1'b0, 8'hFE};
        for (int i = 7; i < 10; i++) begin
            vecs[i].a   = 8'($urandom_range(0, 255));
            vecs[i].b   = 8'($urandom_range(0, 255));
            vecs[i].su  = 1'($urandom_range(0, 1));
            vecs[i].exp = vecs[i].su ? 8'(vecs[i].a - vecs[i].b) : 8'(vecs[i].a + vecs[i].b);
        end
        for (int i = 0; i < 10; i++) begin
            load_a(vecs[i].a);
            load_b(vecs[i].b);
            c = idle(); c.Eu = 1'b1; c.Su = vecs[i].su; c.La_barra = 1'b0; cyc(c);
            c = idle(); c.Ea = 1'b1; show($sformatf("alu[%0d]", i), c, vecs[i].exp);
        end

        // Drive-and-load of A keeps its value; a shared load fills A and B alike.
        load_a(8'h5A);
        c = idle(); c.Ea = 1'b1; c.La_barra = 1'b0; cyc(c);
        c = idle(); c.Ea = 1'b1; show("self_load_a", c, 8'h5A);
        prog(4'h0, 8'h21);
        c = idle(); c.CE_barra = 1'b0; c.La_barra = 1'b0; c.Lb_barra = 1'b0; cyc(c);
        c = idle(); c.Eu = 1'b1; show("dual_load", c, 8'h42);

        // PC wrap and Ep+Cp in the same cycle.
        pulse_clr();
        release_clr();
        for (int i = 0; i < 16; i++) begin
            c = idle(); c.Cp = 1'b1; cyc(c);
        end
        c = idle(); c.Ep = 1'b1; show("pc_wrap", c, 8'h00);
        for (int i = 0; i < 15; i++) begin
            c = idle(); c.Cp = 1'b1; cyc(c);
        end
        c = idle(); c.Ep = 1'b1; c.Cp = 1'b1; show("ep_cp_old", c, 8'h0F);
        c = idle(); c.Ep = 1'b1; show("ep_cp_new", c, 8'h00);
        check("no_conflict", {7'h0, bus_conflict}, 8'h00);

        // Bus conflicts: priority still applies and the flag is sticky until clr.
        load_a(8'h33);
        c = idle(); c.Ea = 1'b1; c.Eu = 1'b1; c.Lb_barra = 1'b0; cyc(c);
        check("conflict_set", {7'h0, bus_conflict}, 8'h01);
        c = idle(); c.Eu = 1'b1; show("conflict_b", c, 8'h66);
        c = idle(); c.Cp = 1'b1; cyc(c);
        c = idle(); c.Ep = 1'b1; c.CE_barra = 1'b0; show("ep_over_ram", c, 8'h01);
        cyc(idle());
        check("conflict_sticky", {7'h0, bus_conflict}, 8'h01);
        pulse_clr();
        check("conflict_clr", {7'h0, bus_conflict}, 8'h00);
        release_clr();
        cyc(idle());
        check("conflict_after", {7'h0, bus_conflict}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sap1_datapath.md
# sap1_datapath

Datapath of the SAP-1 processor: program counter, MAR, 16×8 program RAM, instruction register, accumulator A, register B, adder/subtractor and output register, all sharing one 8-bit internal bus.

- Consumes the 12-bit control word produced each T-state by the controller.
- Returns the IR opcode nibble to the controller.
- Drives the 8-bit output port `W`.
- Includes a RAM programming port, the equivalent of the SAP-1 front-panel switches.

## Interface
Parameters:
- `ADDR_W`, 4: address width (PC, MAR, IR operand).
- `DATA_W`, 8: bus and register width.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `clr`  in  1: reset, asynchronous, active-low.
- `Cp`  in  1: PC increment enable.
- `Ep`  in  1: PC drives bus.
- `Lm_barra`  in  1: active-low, MAR loads bus[3:0].
- `CE_barra`  in  1: active-low, RAM[MAR] drives bus.
- `Li_barra`  in  1: active-low, IR loads bus.
- `Ei_barra`  in  1: active-low, IR[3:0] drives bus.
- `La_barra`  in  1: active-low, A loads bus.
- `Ea`  in  1: A drives bus.
- `Su`  in  1: ALU subtract (1) / add (0).
- `Eu`  in  1: ALU result drives bus.
- `Lb_barra`  in  1: active-low, B loads bus.
- `Lo_barra`  in  1: active-low, output register loads bus.
- `prog_en`  in  1: RAM programming write strobe.
- `prog_addr`  in  4: programming address.
- `prog_data`  in  8: programming data.
- `ri`  out  4: IR[7:4], the opcode to the controller.
- `W`  out  8: output register.
- `bus_conflict`  out  1: sticky flag; set when more than one bus driver is active in a cycle.

## Operation
**Bus source.** The bus source is chosen by fixed priority:
- Priority order: `Ep`, then `!CE_barra`, then `!Ei_barra`, then `Ea`, then `Eu`.
- `Ep` drives `{4'h0, PC}`.
- `!Ei_barra` drives `{4'h0, IR[3:0]}`.
- No driver active: bus = 8'h00.

**Bus conflict.**
- Two or more drivers active in one cycle: `bus_conflict` sets on that rising edge.
- It stays set until `clr` is asserted.
- The bus value still follows the priority order above.

**ALU.**
- Combinational: `Su` = 0 gives A + B; `Su` = 1 gives A − B (two's complement).
- Result is truncated to 8 bits, modulo 256. No carry or flags are produced.

**Registers.**
- Loads are synchronous and take the bus value present before the edge.
- Several loads in the same cycle are allowed; each captures the same bus value.
- A register may drive the bus and load in the same cycle: it captures its own old value, no change.

**Program counter.**
- `Cp`: PC ← PC + 1 with 4-bit wrap, 15 → 0.
- `Ep` with `Cp` in the same cycle: the bus shows the old PC and the PC increments at the edge.

**RAM.**
- Asynchronous read of RAM[MAR].
- Synchronous write on the rising edge when `prog_en` = 1: RAM[prog_addr] ← prog_data.
- Writes are accepted while `clr` is low.
- Write and read of the same address in one cycle: the read shows the old data.
- RAM contents are not affected by `clr`.

**Output.** `ri` = IR[7:4] continuously.

## Timing
- **Reset.** `clr` low asynchronously forces PC, MAR, IR, A, B and W to 0, and `bus_conflict` to 0. As a result `ri` = 0 and `W` = 0.
- **Reset release.** Synchronous use resumes at the first rising edge with `clr` high.
- **Latency.**
  - Register load: visible 1 cycle after the edge.
  - ALU output: 0 cycles, combinational from A, B and `Su`.
  - RAM read to bus: 0 cycles from MAR.
- **Reset mid-instruction.** Registers clear immediately and no partial load completes. The controller restarts fetch from PC = 0.

## Structure
- **`sap1_pkg`** holds:
  - `ADDR_W` and `DATA_W` defaults;
  - opcode constants LDA = 4'h0, ADD = 4'h1, SUB = 4'h2, OUT = 4'hE, HLT = 4'hF;
  - a packed struct `ctrl_word_t` with the 12 control bits in controller order: Cp, Ep, Lm_barra, CE_barra, Li_barra, Ei_barra, La_barra, Ea, Su, Eu, Lb_barra, Lo_barra.
- **`sap1_ram16x8`** is the one sub-module: asynchronous read, synchronous write, no reset.
- Bus multiplexer, conflict detector, registers and ALU live in `sap1_datapath`.

## Test plan
- **Reset.** Load registers with nonzero values, then pulse `clr` low mid-cycle → PC, MAR, IR, A, B, W = 0 and `ri` = 0, without waiting for a clock edge. RAM contents are unchanged.
- **Programming and LDA.** With `clr` low, program RAM[0] = 8'h09 and RAM[9] = 8'h1C. Release `clr` and drive the fetch control words, then LDA execute → `ri` = 4'h0, A = 8'h1C, PC = 1.
- **ADD and OUT.**
  - Setup: A = 8'hF0; B loaded from RAM holding 8'h20.
  - `Eu` with `La_barra` low, `Su` = 0 → A = 8'h10 (wraps modulo 256).
  - `Ea` with `Lo_barra` low → `W` = 8'h10.
- **SUB.** A = 8'h05, B = 8'h07, `Su` = 1, `Eu` with `La_barra` low → A = 8'hFE.
- **PC wrap.** Apply `Cp` for 16 cycles from PC = 0 → PC returns to 0. With `Ep` and `Cp` in the same cycle → bus = old PC and PC increments.
- **Bus conflict.** `Ea` and `Eu` together with `Lb_barra` low, A = 8'h33 → B = 8'h33 (A has priority). `bus_conflict` = 1 and stays 1 until `clr` low.
